seg_scan: RTL and testbench
===========================

Name: seg_scan

Overview:
Display-side consumer of the divider's 7-segment scan clock. It samples `segclk` (a ~381 Hz square wave from the clock divider) in the 50 MHz `clk` domain and turns each rising edge into a one-cycle scan tick. On each tick it time-multiplexes a 4-digit, common-anode 7-segment display, with anti-ghost blanking and per-frame value snapshotting. It sits between the game-state/score logic and the board's seg/an pins.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; value width is 4*NUM_DIGITS.
- BLANK_CYCLES, 4: clk cycles with all anodes off after every digit change; legal range 1..255.
- LZ_SUPPRESS, 1: 1 blanks leading zero digits; digit 0 is always shown.

Ports:
- clk  in  1  50 MHz master clock.
- clr_n  in  1  reset; synchronous, active-low.
- segclk  in  1  scan clock from the divider; treated as asynchronous.
- value  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i.
- digit_en  in  NUM_DIGITS  per-digit enable; 0 forces that anode off.
- dp_in  in  NUM_DIGITS  per-digit decimal point request; 1 means lit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  NUM_DIGITS  anodes, active-low.
- frame_start  out  1  one-cycle pulse when a new frame snapshot is taken.

Behaviour:
- Reset (clr_n=0 at a clk edge):
  - Sync flops and edge flop clear to 0.
  - idx=0, state=BLANK, cnt=BLANK_CYCLES-1.
  - an=all 1, seg=7'h7F, dp=1, frame_start=0.
  - Frame registers (value, digit_en, dp) clear to 0.
- Synchronizer: segclk passes through 2 flops (s1, s2) plus a history flop s3.
  - tick = s2 & ~s3.
  - A segclk rise sampled at edge N gives tick=1 during cycle N+2.
  - Exactly one tick per segclk rising edge; no tick on the falling edge.
- Tick processing (registered, effective at the next edge):
  - idx <= (idx == NUM_DIGITS-1) ? 0 : idx+1.
  - an <= all 1; state <= BLANK; cnt <= BLANK_CYCLES-1.
  - seg and dp are loaded from the decode of the new digit, using frame registers.
  - When the new idx is 0, the frame registers first capture value/digit_en/dp_in. Decode for digit 0 uses the freshly captured data, and frame_start=1 for that one cycle.
- BLANK state:
  - If cnt==0: an <= ~(1<<idx) when the digit is visible, else all 1; state <= DRIVE.
  - Otherwise cnt <= cnt-1.
  - Net effect: an is all 1 for exactly BLANK_CYCLES cycles.
- DRIVE state: holds an/seg/dp until the next tick.
- A tick arriving during BLANK takes priority: idx advances and blanking restarts.
- Visibility: a digit is visible iff frame digit_en[idx]=1, and, when LZ_SUPPRESS=1, idx=0 or some frame nibble at index >= idx is nonzero.
- A digit that is not visible keeps seg=7'h7F and dp=1 as well as the anode off.
- Decode: standard hex 0-F, active-low.
  - 0->7'h40, 1->7'h79, 8->7'h00, A->7'h08, F->7'h0E.
- Live inputs (value, digit_en, dp_in) affect outputs only at frame capture; no mid-frame tearing.
- Reset mid-frame: all outputs return to reset values on the next edge. Scanning resumes at idx=0 after the first post-reset tick advances the counter, wrapping 0->1; the first capture happens at the next wrap to 0.

Decomposition:
- Shared package seg_pkg: the 16-entry hex-to-segment constant table, SEG_BLANK=7'h7F, and the state enum {BLANK, DRIVE}.
- One sub-module, seg_hex_decode: combinational nibble-to-7-bit decode. Reused by the score displays.
- Synchronizer and edge detect stay inline.

Test Plan:
1. Edge timing: hold clr_n=0 for 3 cycles, release, raise segclk at edge 10. Required: tick in cycle 12; an all 1 for exactly 4 cycles (BLANK_CYCLES=4); only one tick per rise.
2. Full frame: value=16'h12AF, digit_en=4'hF, dp_in=4'b0010, 5 segclk rises.
   - Required: frame_start pulses once.
   - Digit 0: seg=7'h0E, an=4'b1110. Digit 1: seg=7'h08, dp=0, an=4'b1101. Digit 2: seg=7'h24, an=4'b1011. Digit 3: seg=7'h79, an=4'b0111.
3. Leading-zero suppression: value=16'h0050, all enabled.
   - Required: digits 2 and 3 have an all 1 and seg=7'h7F.
   - Digit 1 shows 5 (7'h12); digit 0 shows 0 (7'h40).
   - value=16'h0000: only digit 0 lit.
4. No tearing: change value from 16'h1111 to 16'h2222 while idx=2. Required: digit 3 still shows 1; the new value appears only after the next frame_start.
5. Tick during blanking: two segclk rises 6 cycles apart with BLANK_CYCLES=8. Required: idx advances twice, blanking restarts, and an never drives the skipped digit.
6. Mid-operation reset: assert clr_n=0 for 1 cycle while in DRIVE on digit 2. Required: next edge gives an=4'hF, seg=7'h7F, dp=1, idx=0; no digit lights before the first wrap captures fresh data.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display path: hex segment table,
// the blank pattern and the scan state type.
package seg_pkg;

  // All segments off (active-low)
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns, index = hex nibble (entry 15 first)
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // BLANK: anodes held off after a digit change; DRIVE: digit lit until next tick
  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble to active-low 7-segment pattern.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Table lookup; shared with the score displays
  always_comb begin
    seg = HEX_SEG[nib];
  end

endmodule

// File: rtl/seg_scan.sv
// 4-digit common-anode display scanner driven by the divider's segclk.
// Each segclk rise advances one digit, blanks all anodes for a few clk
// cycles to avoid ghosting, and a new frame snapshot is taken on wrap to 0.
module seg_scan
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 4,
  parameter int LZ_SUPPRESS  = 1
) (
  input  logic                    clk,
  input  logic                    clr_n,
  input  logic                    segclk,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int VW = 4 * NUM_DIGITS;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0] BLANK_INIT = 8'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  logic s1, s2, s3;
  logic tick;

  scan_state_t state, state_next;
  logic [IW-1:0] idx, idx_next, idx_wrap;
  logic [7:0] cnt, cnt_next;
  logic [NUM_DIGITS-1:0] an_next;
  logic [6:0] seg_next;
  logic dp_next;
  logic fs_next;

  logic [VW-1:0] frame_val;
  logic [NUM_DIGITS-1:0] frame_en;
  logic [NUM_DIGITS-1:0] frame_dp;

  logic capture;
  logic [VW-1:0] src_val;
  logic [NUM_DIGITS-1:0] src_en;
  logic [NUM_DIGITS-1:0] src_dp;
  logic [3:0] dec_nib;
  logic [6:0] dec_seg;
  logic tick_vis;
  logic cur_vis;

  // A digit is visible when enabled and, with suppression, it is digit 0
  // or some nibble at or above it is nonzero
  function automatic logic digit_visible(input logic [VW-1:0] v,
                                         input logic [NUM_DIGITS-1:0] en,
                                         input logic [IW-1:0] i);
    logic any_nz;
    any_nz = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(i) && v[4*k +: 4] != 4'h0) any_nz = 1'b1;
    end
    return en[i] && (LZ_SUPPRESS == 0 || i == '0 || any_nz);
  endfunction

  function automatic logic [3:0] nibble_at(input logic [VW-1:0] v,
                                           input logic [IW-1:0] i);
    logic [3:0] n;
    n = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k == int'(i)) n = v[4*k +: 4];
    end
    return n;
  endfunction

  // Two-flop synchronizer plus history flop for rising-edge detection
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= segclk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;

  // Next digit index and the data it decodes from (fresh inputs on wrap)
  always_comb begin
    idx_wrap = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    capture  = tick && (idx_wrap == '0);
    src_val  = capture ? value    : frame_val;
    src_en   = capture ? digit_en : frame_en;
    src_dp   = capture ? dp_in    : frame_dp;
    dec_nib  = nibble_at(src_val, idx_wrap);
    tick_vis = digit_visible(src_val, src_en, idx_wrap);
    cur_vis  = digit_visible(frame_val, frame_en, idx);
  end

  seg_hex_decode u_dec (
    .nib (dec_nib),
    .seg (dec_seg)
  );

  // Scan state register
  always_ff @(posedge clk) begin
    if (!clr_n) state <= BLANK;
    else        state <= state_next;
  end

  // A tick always restarts blanking; blanking ends when the counter expires
  always_comb begin
    state_next = state;
    if (tick) begin
      state_next = BLANK;
    end else if (state == BLANK && cnt == 8'd0) begin
      state_next = DRIVE;
    end
  end

  // Next values for index, blank counter and display pins
  always_comb begin
    idx_next = idx;
    cnt_next = cnt;
    an_next  = an;
    seg_next = seg;
    dp_next  = dp;
    fs_next  = 1'b0;
    if (tick) begin
      idx_next = idx_wrap;
      cnt_next = BLANK_INIT;
      an_next  = '1;
      seg_next = tick_vis ? dec_seg : SEG_BLANK;
      dp_next  = tick_vis ? ~src_dp[idx_wrap] : 1'b1;
      fs_next  = capture;
    end else if (state == BLANK) begin
      if (cnt == 8'd0) begin
        an_next = cur_vis ? ~(NUM_DIGITS'(1) << idx) : '1;
      end else begin
        cnt_next = cnt - 8'd1;
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      idx         <= '0;
      cnt         <= BLANK_INIT;
      an          <= '1;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      idx         <= idx_next;
      cnt         <= cnt_next;
      an          <= an_next;
      seg         <= seg_next;
      dp          <= dp_next;
      frame_start <= fs_next;
    end
  end

  // Frame snapshot, taken only when the scan wraps back to digit 0
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      frame_val <= '0;
      frame_en  <= '0;
      frame_dp  <= '0;
    end else if (capture) begin
      frame_val <= value;
      frame_en  <= digit_en;
      frame_dp  <= dp_in;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Randomized bench for seg_scan against a frame/digit-level display model.
module tb_seg_scan;

  localparam int ND = 4;
  localparam int BC = 4;
  localparam int NCYC = 5000;

  logic clk = 1'b0;
  logic clr_n;
  logic segclk;
  logic [15:0] value;
  logic [3:0] digit_en;
  logic [3:0] dp_in;
  logic [6:0] seg;
  logic dp;
  logic [3:0] an;
  logic frame_start;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: current digit, snapshot, cycles since the last digit change
  logic samples[$];
  int m_idx;
  int m_since;
  logic [15:0] m_val;
  logic [3:0] m_en;
  logic [3:0] m_dp;
  logic m_fs;

  int phase_left = 1;

  seg_scan #(.NUM_DIGITS(ND), .BLANK_CYCLES(BC), .LZ_SUPPRESS(1)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .segclk      (segclk),
    .value       (value),
    .digit_en    (digit_en),
    .dp_in       (dp_in),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  // 50 MHz clock
  always #10 clk = ~clk;

  function automatic logic [6:0] hexPattern(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%h want=%h", tag, cyc, obs, exp);
    end
  endtask

  // Advance the model by one clk edge using the inputs present at that edge
  task automatic modelEdge();
    logic tick;
    if (!clr_n) begin
      samples = '{1'b0, 1'b0, 1'b0, 1'b0};
      m_idx = 0;
      m_since = 0;
      m_val = '0;
      m_en = '0;
      m_dp = '0;
      m_fs = 1'b0;
    end else begin
      samples.push_back(segclk);
      void'(samples.pop_front());
      // A rise first seen at edge E-2 takes effect at edge E
      tick = samples[1] && !samples[0];
      if (tick) begin
        m_idx = (m_idx + 1) % ND;
        if (m_idx == 0) begin
          m_val = value;
          m_en = digit_en;
          m_dp = dp_in;
        end
        m_since = 0;
        m_fs = (m_idx == 0);
      end else begin
        if (m_since < 100000) m_since++;
        m_fs = 1'b0;
      end
    end
  endtask

  task automatic compareAll();
    logic vis;
    logic [3:0] nib;
    logic [3:0] exp_an;
    nib = 4'((m_val >> (4 * m_idx)) & 16'hF);
    vis = m_en[m_idx] && (m_idx == 0 || (m_val >> (4 * m_idx)) != 16'h0);
    exp_an = (vis && m_since >= BC) ? ~(4'b0001 << m_idx) : 4'hF;
    checkOutput("an", {12'h0, an}, {12'h0, exp_an});
    checkOutput("seg", {9'h0, seg}, {9'h0, vis ? hexPattern(nib) : 7'h7F});
    checkOutput("dp", {15'h0, dp}, {15'h0, vis ? ~m_dp[m_idx] : 1'b1});
    checkOutput("frame_start", {15'h0, frame_start}, {15'h0, m_fs});
  endtask

  function automatic logic [15:0] randValue();
    logic [15:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) begin
      if ($urandom_range(0, 1) == 1) v[4*k +: 4] = 4'($urandom_range(0, 15));
    end
    return v;
  endfunction

  // Random segclk phases, occasional input changes and rare resets
  task automatic applyStimulus();
    phase_left--;
    if (phase_left <= 0) begin
      segclk = ~segclk;
      phase_left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 24);
    end
    if ($urandom_range(0, 29) == 0) value = randValue();
    if ($urandom_range(0, 59) == 0)
      digit_en = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
    if ($urandom_range(0, 39) == 0) dp_in = 4'($urandom_range(0, 15));
    clr_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
  endtask

  initial begin
    clr_n = 1'b0;
    segclk = 1'b0;
    value = 16'h12AF;
    digit_en = 4'hF;
    dp_in = 4'b0010;
    for (cyc = 0; cyc < NCYC; cyc++) begin
      if (cyc < 3) clr_n = 1'b0;
      else applyStimulus();
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      compareAll();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
